// File: rtl/run_sequencer_if.sv
// Host-facing bundle of the run sequencer: run request, core handshake,
// program select, status flags and the cycle-count read port.
interface run_sequencer_if #(
  parameter int NPROG = 3,
  parameter int CW    = 16
);
  logic             Go;
  logic             Ack;
  logic             Start;
  logic [2:0]       ProgSel;
  logic             Busy;
  logic             Done;
  logic [NPROG-1:0] TimeoutMask;
  logic [2:0]       RdSel;
  logic [CW-1:0]    RdCycles;

  modport slave (
    input  Go, Ack, RdSel,
    output Start, ProgSel, Busy, Done, TimeoutMask, RdCycles
  );

  modport master (
    output Go, Ack, RdSel,
    input  Start, ProgSel, Busy, Done, TimeoutMask, RdCycles
  );
endinterface

// File: rtl/run_sequencer.sv
// Runs programs 0..NPROG-1 on the core per Go request, strobing Start and
// timing each run until Ack or timeout; results readable via RdSel/RdCycles.
module run_sequencer #(
  parameter int          NPROG     = 3,
  parameter int          CW        = 16,
  parameter int unsigned TIMEOUT   = 16'hFFFF,
  parameter int          START_CYC = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  run_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, RUN, GAP, DONE} state_e;

  localparam logic [CW-1:0] PH_INIT   = CW'(START_CYC - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_VAL    = CW'(TIMEOUT);
  localparam logic [2:0]    LAST_PROG = 3'(NPROG - 1);

  state_e           state_q, state_d;
  logic [2:0]       prog_q, prog_d;
  logic [CW-1:0]    phase_q, phase_d;
  logic [CW-1:0]    run_q, run_d;
  logic [CW-1:0]    slot_q [NPROG];
  logic [CW-1:0]    slot_d [NPROG];
  logic [NPROG-1:0] tmask_q, tmask_d;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      prog_q  <= '0;
      phase_q <= '0;
      run_q   <= '0;
      tmask_q <= '0;
      for (int i = 0; i < NPROG; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      phase_q <= phase_d;
      run_q   <= run_d;
      tmask_q <= tmask_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    phase_d = phase_q;
    run_d   = run_q;
    tmask_d = tmask_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.Go) begin
          for (int i = 0; i < NPROG; i++) slot_d[i] = '0;
          tmask_d = '0;
          prog_d  = '0;
          phase_d = PH_INIT;
          state_d = START;
        end
      end
      START: begin
        if (phase_q == '0) begin
          run_d   = '0;
          state_d = RUN;
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end
      RUN: begin
        // Ack wins over the timeout when both land on the last allowed cycle.
        if (bus.Ack) begin
          for (int i = 0; i < NPROG; i++)
            if (prog_q == 3'(i)) slot_d[i] = run_q;
          state_d = GAP;
        end else if (run_q == RUN_LAST) begin
          for (int i = 0; i < NPROG; i++)
            if (prog_q == 3'(i)) begin
              slot_d[i]  = TO_VAL;
              tmask_d[i] = 1'b1;
            end
          state_d = GAP;
        end else begin
          run_d = run_q + CW'(1);
        end
      end
      GAP: begin
        if (prog_q == LAST_PROG) begin
          state_d = DONE;
        end else begin
          prog_d  = prog_q + 3'd1;
          phase_d = PH_INIT;
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Start       = (state_q == START);
  assign bus.Busy        = (state_q == START) || (state_q == RUN) || (state_q == GAP);
  assign bus.Done        = (state_q == DONE);
  assign bus.ProgSel     = prog_q;
  assign bus.TimeoutMask = tmask_q;

  always_comb begin
    bus.RdCycles = '0;
    for (int i = 0; i < NPROG; i++)
      if (bus.RdSel == 3'(i)) bus.RdCycles = slot_q[i];
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: builds the expected cycle timeline from the
// sequencing rules, drives the core's Ack from it and compares every cycle.
module tb_run_sequencer;
  localparam int NPROG     = 3;
  localparam int CW        = 16;
  localparam int TIMEOUT   = 20;
  localparam int START_CYC = 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  run_sequencer_if #(.NPROG(NPROG), .CW(CW)) bus ();

  run_sequencer #(
    .NPROG(NPROG), .CW(CW), .TIMEOUT(TIMEOUT), .START_CYC(START_CYC)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Per-program core behaviour: ack_at < 0 means the core never acks.
  int ack_at   [NPROG];
  bit stale    [NPROG];
  int exp_slot [NPROG];
  bit exp_to   [NPROG];
  bit go_noise;

  typedef struct { bit start; bit busy; bit done; int prog; bit ack; int stored; } ent_t;
  typedef struct { logic [5:0] ctrl; logic [NPROG-1:0] mask; logic [CW-1:0] rd; int sel; } obs_t;
  ent_t tl  [$];
  obs_t obs [$];

  function automatic void build();
    ent_t e;
    int len;
    bit timed;
    tl.delete();
    for (int p = 0; p < NPROG; p++) begin
      timed       = !(ack_at[p] >= 0 && ack_at[p] < TIMEOUT);
      exp_slot[p] = timed ? TIMEOUT : ack_at[p];
      exp_to[p]   = timed;
      len         = timed ? TIMEOUT : ack_at[p] + 1;
      for (int c = 0; c < START_CYC; c++) begin
        e = '{1'b1, 1'b1, 1'b0, p, stale[p], p}; tl.push_back(e);
      end
      for (int n = 0; n < len; n++) begin
        e = '{1'b0, 1'b1, 1'b0, p, (!timed && n == ack_at[p]), p}; tl.push_back(e);
      end
      e = '{1'b0, 1'b1, 1'b0, p, 1'b0, p + 1}; tl.push_back(e);
    end
    e = '{1'b0, 1'b0, 1'b1, NPROG - 1, 1'b0, NPROG}; tl.push_back(e);
  endfunction

  function automatic logic [5:0] ectrl(ent_t e);
    return {e.start, e.busy, e.done, 3'(e.prog)};
  endfunction

  function automatic logic [NPROG-1:0] exp_mask(int stored);
    logic [NPROG-1:0] m = '0;
    for (int p = 0; p < NPROG; p++) if (p < stored && exp_to[p]) m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [CW-1:0] exp_rd(int sel, int stored);
    if (sel < NPROG && sel < stored) return CW'(exp_slot[sel]);
    return '0;
  endfunction

  // Issues Go from IDLE/DONE and walks the timeline, recording outputs each cycle.
  // If rst_at >= 0, Reset is pulsed low during that timeline cycle instead.
  task automatic drive_run(input int rst_at);
    obs_t o;
    obs.delete();
    bus.Go = 1'b1;
    @(posedge Clk); #1;
    bus.Go = 1'b0;
    for (int i = 0; i < tl.size(); i++) begin
      if (i == rst_at) begin
        Reset   = 1'b0;
        bus.Ack = 1'($urandom);
        @(posedge Clk); #1;
        Reset   = 1'b1;
        bus.Ack = 1'b0;
        return;
      end
      bus.Ack   = tl[i].ack;
      bus.Go    = (go_noise && tl[i].busy) ? 1'($urandom) : 1'b0;
      bus.RdSel = 3'($urandom_range(0, 7));
      #1;
      o = '{{bus.Start, bus.Busy, bus.Done, bus.ProgSel}, bus.TimeoutMask, bus.RdCycles, int'(bus.RdSel)};
      obs.push_back(o);
      @(posedge Clk); #1;
    end
    bus.Go  = 1'b0;
    bus.Ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.Go    = 1'($urandom);
      bus.Ack   = 1'($urandom);
      bus.RdSel = 3'($urandom_range(0, 7));
      @(posedge Clk); #1;
      total++;
      if ({bus.Start, bus.Busy, bus.Done, bus.ProgSel, bus.TimeoutMask, bus.RdCycles} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%b/%b/%b/%0d/%b/%0d want all 0", c, bus.Start,
                 bus.Busy, bus.Done, bus.ProgSel, bus.TimeoutMask, bus.RdCycles);
      end
    end
    bus.Go  = 1'b0;
    bus.Ack = 1'b0;
    Reset   = 1'b1;
    @(posedge Clk); #1;
    total++;
    if ({bus.Start, bus.Busy, bus.Done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle_hold got=%b want=000", {bus.Start, bus.Busy, bus.Done});
    end
  endtask

  task automatic test_basic();
    ack_at = '{5, 0, 12}; stale = '{0, 0, 0}; go_noise = 0;
    build();
    drive_run(-1);
    for (int i = 0; i < obs.size(); i++) begin
      total++;
      if (obs[i].ctrl !== ectrl(tl[i])) begin
        bad++; $display("FAIL basic_ctrl cyc=%0d got=%b want=%b", i, obs[i].ctrl, ectrl(tl[i]));
      end
      total++;
      if (obs[i].mask !== exp_mask(tl[i].stored)) begin
        bad++; $display("FAIL basic_mask cyc=%0d got=%b want=%b", i, obs[i].mask, exp_mask(tl[i].stored));
      end
      total++;
      if (obs[i].rd !== exp_rd(obs[i].sel, tl[i].stored)) begin
        bad++; $display("FAIL basic_rd cyc=%0d sel=%0d got=%0d want=%0d", i, obs[i].sel, obs[i].rd,
                        exp_rd(obs[i].sel, tl[i].stored));
      end
    end
    for (int s = 0; s < 8; s++) begin
      bus.RdSel = 3'(s); #1;
      total++;
      if (bus.RdCycles !== exp_rd(s, NPROG)) begin
        bad++; $display("FAIL basic_done_rd sel=%0d got=%0d want=%0d", s, bus.RdCycles, exp_rd(s, NPROG));
      end
    end
  endtask

  task automatic test_timeout();
    // Program 2 acks on the last allowed RUN cycle: recorded, not a timeout.
    ack_at = '{-1, 3, TIMEOUT - 1}; stale = '{0, 0, 0}; go_noise = 0;
    build();
    drive_run(-1);
    for (int i = 0; i < obs.size(); i++) begin
      total++;
      if (obs[i].ctrl !== ectrl(tl[i])) begin
        bad++; $display("FAIL timeout_ctrl cyc=%0d got=%b want=%b", i, obs[i].ctrl, ectrl(tl[i]));
      end
      total++;
      if (obs[i].mask !== exp_mask(tl[i].stored)) begin
        bad++; $display("FAIL timeout_mask cyc=%0d got=%b want=%b", i, obs[i].mask, exp_mask(tl[i].stored));
      end
      total++;
      if (obs[i].rd !== exp_rd(obs[i].sel, tl[i].stored)) begin
        bad++; $display("FAIL timeout_rd cyc=%0d sel=%0d got=%0d want=%0d", i, obs[i].sel, obs[i].rd,
                        exp_rd(obs[i].sel, tl[i].stored));
      end
    end
    bus.RdSel = 3'd0; #1;
    total++;
    if (bus.RdCycles !== CW'(TIMEOUT) || bus.TimeoutMask !== 3'b001) begin
      bad++; $display("FAIL timeout_slot0 got=%0d/%b want=%0d/001", bus.RdCycles, bus.TimeoutMask, TIMEOUT);
    end
  endtask

  task automatic test_stale_ack();
    ack_at = '{0, 4, 0}; stale = '{1, 1, 1}; go_noise = 0;
    build();
    drive_run(-1);
    for (int i = 0; i < obs.size(); i++) begin
      total++;
      if (obs[i].ctrl !== ectrl(tl[i])) begin
        bad++; $display("FAIL stale_ctrl cyc=%0d got=%b want=%b", i, obs[i].ctrl, ectrl(tl[i]));
      end
      total++;
      if (obs[i].rd !== exp_rd(obs[i].sel, tl[i].stored)) begin
        bad++; $display("FAIL stale_rd cyc=%0d sel=%0d got=%0d want=%0d", i, obs[i].sel, obs[i].rd,
                        exp_rd(obs[i].sel, tl[i].stored));
      end
    end
  endtask

  task automatic test_go_busy();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NPROG; p++) ack_at[p] = $urandom_range(0, 9);
      stale = '{0, 0, 0}; go_noise = 1;
      build();
      drive_run(-1);
      for (int i = 0; i < obs.size(); i++) begin
        total++;
        if (obs[i].ctrl !== ectrl(tl[i])) begin
          bad++; $display("FAIL gobusy_ctrl run=%0d cyc=%0d got=%b want=%b", r, i, obs[i].ctrl, ectrl(tl[i]));
        end
        total++;
        if (obs[i].mask !== exp_mask(tl[i].stored) || obs[i].rd !== exp_rd(obs[i].sel, tl[i].stored)) begin
          bad++; $display("FAIL gobusy_result run=%0d cyc=%0d got=%b/%0d want=%b/%0d", r, i, obs[i].mask,
                          obs[i].rd, exp_mask(tl[i].stored), exp_rd(obs[i].sel, tl[i].stored));
        end
      end
    end
    go_noise = 0;
  endtask

  task automatic test_reset_mid();
    int rst_at = -1;
    ack_at = '{3, 10, 2}; stale = '{0, 0, 0}; go_noise = 0;
    build();
    for (int i = 0; i < tl.size(); i++)
      if (rst_at < 0 && tl[i].prog == 1 && !tl[i].start && tl[i].busy && tl[i].stored == 1) rst_at = i + 4;
    drive_run(rst_at);
    for (int i = 0; i < obs.size(); i++) begin
      total++;
      if (obs[i].ctrl !== ectrl(tl[i])) begin
        bad++; $display("FAIL rstmid_ctrl cyc=%0d got=%b want=%b", i, obs[i].ctrl, ectrl(tl[i]));
      end
    end
    total++;
    if ({bus.Start, bus.Busy, bus.Done, bus.ProgSel, bus.TimeoutMask} !== '0) begin
      bad++; $display("FAIL rstmid_idle got=%b/%b/%b/%0d/%b want all 0", bus.Start, bus.Busy, bus.Done,
                      bus.ProgSel, bus.TimeoutMask);
    end
    for (int s = 0; s < 8; s++) begin
      bus.RdSel = 3'(s); #1;
      total++;
      if (bus.RdCycles !== '0) begin
        bad++; $display("FAIL rstmid_slot sel=%0d got=%0d want=0", s, bus.RdCycles);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < NPROG; p++) begin
        ack_at[p] = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TIMEOUT);
        stale[p]  = 1'($urandom);
      end
      go_noise = 1'($urandom);
      build();
      drive_run(-1);
      for (int i = 0; i < obs.size(); i++) begin
        total++;
        if (obs[i].ctrl !== ectrl(tl[i])) begin
          bad++; $display("FAIL rand_ctrl run=%0d cyc=%0d got=%b want=%b", r, i, obs[i].ctrl, ectrl(tl[i]));
        end
        total++;
        if (obs[i].mask !== exp_mask(tl[i].stored) || obs[i].rd !== exp_rd(obs[i].sel, tl[i].stored)) begin
          bad++; $display("FAIL rand_result run=%0d cyc=%0d sel=%0d got=%b/%0d want=%b/%0d", r, i, obs[i].sel,
                          obs[i].mask, obs[i].rd, exp_mask(tl[i].stored), exp_rd(obs[i].sel, tl[i].stored));
        end
      end
    end
    go_noise = 0;
  endtask

  initial begin
    bus.Go = 1'b0; bus.Ack = 1'b0; bus.RdSel = 3'd0; go_noise = 0;
    @(posedge Clk); #1;
    test_reset();
    test_basic();
    test_timeout();
    test_stale_ack();
    test_go_busy();
    test_reset_mid();
    test_basic();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Sequencing controller that sits between the host/testbench and the 9-bit processor core. On a single `Go` request it runs programs 0..NPROG-1 back-to-back: it drives `ProgSel`, holds the core's `Start` for a fixed window, then waits for the core's `Ack` (HALT reached). Each run is bounded by a timeout. It records a per-program cycle count and a timeout flag, readable through a side port. It replaces hand-driven Start/Ack sequencing in the bench and in the top-level wrapper.

## Interface

Parameters:
- `NPROG`, 3: number of programs to run per `Go`; must be 1..8.
- `CW`, 16: cycle-counter width.
- `TIMEOUT`, 16'hFFFF: maximum RUN cycles per program before abort; must be ≥1.
- `START_CYC`, 2: cycles `Start` is held high per program; must be ≥1.

Ports:
- `Clk`, input, 1: clock; all logic on posedge.
- `Reset`, input, 1: reset; synchronous and active-low (asserted when 0, sampled on posedge Clk).
- `Go`, input, 1: run request; sampled only in IDLE or DONE.
- `Ack`, input, 1: core done flag; combinational from the core, valid every cycle after `Start` drops.
- `Start`, output, 1: core start/PC-reset strobe.
- `ProgSel`, output, 3: index of the program being run; drives the loader/ROM bank select.
- `Busy`, output, 1: high in START, RUN and GAP.
- `Done`, output, 1: high in DONE.
- `TimeoutMask`, output, NPROG: bit i set means program i hit TIMEOUT.
- `RdSel`, input, 3: cycle-count read index.
- `RdCycles`, output, CW: recorded count of program `RdSel`; combinational read; 0 if `RdSel` ≥ NPROG.

## Operation

- States: IDLE, START, RUN, GAP, DONE.
- **IDLE**
  - `Go`=1: clear all count slots and `TimeoutMask`, set `ProgSel`=0, go to START.
- **START**
  - `Start`=1 for exactly START_CYC cycles. A phase counter loads START_CYC-1 on entry and counts down.
  - `Ack` is ignored.
  - At phase 0, go to RUN and clear the run counter to 0.
- **RUN**
  - `Start`=0. `Ack` is sampled every cycle, starting with the first RUN cycle.
  - `Ack`=1: store the run counter value (RUN cycles before the Ack cycle; the Ack cycle itself is not counted) into slot `ProgSel`, then go to GAP.
  - `Ack`=0 and run counter = TIMEOUT-1: store TIMEOUT into the slot, set `TimeoutMask[ProgSel]`, go to GAP.
  - Otherwise increment the run counter.
- **GAP**
  - One cycle, `Start`=0.
  - If `ProgSel`=NPROG-1, go to DONE.
  - Else increment `ProgSel` and go to START.
- **DONE**
  - Results hold.
  - `Go`=1: identical to Go in IDLE (results clear, restart at program 0).
- `Go` is ignored in START, RUN and GAP. It is level-sensitive; holding it high in DONE restarts immediately.
- Width rules:
  - Run counter is CW bits; TIMEOUT ≤ 2^CW-1 guarantees no wrap.
  - `ProgSel` increments only in GAP and never exceeds NPROG-1.
- Reset while `Reset`=0, regardless of state:
  - state = IDLE, `Start`=0, `ProgSel`=0, `Busy`=0, `Done`=0, `TimeoutMask`=0, all slots 0, run/phase counters 0.
  - A run in progress is abandoned with no partial result.

## Timing

- All outputs except `RdCycles` are registered or decoded from registered state only; none depends combinationally on `Go` or `Ack`.
- `Go` sampled high at edge k: `Start`=1 and `Busy`=1 from cycle k+1 through k+START_CYC; the first RUN cycle is k+START_CYC+1.
- `Ack` high in RUN cycle n (n=0 is the first RUN cycle): slot = n, readable from the next cycle; GAP follows in the next cycle.
- Per-program overhead: START_CYC + 1 (Ack cycle) + 1 (GAP) cycles beyond the recorded count.
- Last program: DONE is entered the cycle after GAP. `Done` rises then and `Busy` falls in the same cycle.
- Reset release: first state transition possible at the first posedge with `Reset`=1.

## Test plan

- **Basic run.** Defaults. Pulse `Go`. Model the core with Ack high after 5, 0 and 12 RUN cycles. Expect counts 5, 0, 12; `TimeoutMask`=000; `Start` high exactly 2 cycles per program; `Done` high 1 cycle after the last GAP.
- **Timeout.** TIMEOUT=20, NPROG=2. Program 0 never acks; program 1 acks at n=3. Expect slot0=20, slot1=3, `TimeoutMask`=01. RUN lasts exactly 20 cycles for program 0.
- **Stale Ack.** Hold `Ack`=1 during START. It must be ignored: no state change, `Start` still held START_CYC cycles. With Ack still high at the first RUN cycle, expect count 0.
- **Go while busy.** Toggle `Go` during RUN. No restart and no result change. `Go` held high in DONE restarts: `TimeoutMask` and counts clear, `ProgSel`=0, `Start` rises the next cycle.
- **Reset mid-run.** Drive `Reset`=0 for 1 cycle during RUN of program 1. Next cycle: IDLE with all outputs 0 and all slots 0. A later `Go` runs cleanly from program 0.
- **Read port.** `RdSel`=NPROG returns 0. `RdSel` sweep during RUN returns the already-stored slots and 0 for pending ones.
